lb_frame_sequencer: RTL and testbench

- Sequences the raw pixel stream into the 5x5 line buffer. The line buffer has no handshake and no sync clear, so its col/row counters stay aligned only if it gets exactly WIDTH*HEIGHT beats per frame.
- This block frames the stream on SOF, repairs malformed lines (pads short lines, drops excess pixels on long ones), arms frames on command, and reports status.
- Sits between the frame source (camera/DMA stream) and the line buffer feeding gradient/LK accumulation.

---
 rtl/lb_seq_pkg.sv | 21 ++
 rtl/lb_frame_sequencer_if.sv | 23 ++
 rtl/lb_pos_counter.sv | 43 ++++
 rtl/lb_frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_lb_frame_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_seq_pkg.sv
// lb_seq_pkg: shared state encoding, widths and helpers for the
// line-buffer frame sequencer and its position counter.
package lb_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        STREAM,
        PAD,
        DROP,
        END
    } seq_state_t;

    localparam int FRAME_CNT_W = 16;

    // Counter width that stays legal for a degenerate size of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lb_frame_sequencer_if.sv
// lb_frame_sequencer_if: pixel source stream with valid/ready handshake.
// master = frame source, slave = sequencer.
interface lb_frame_sequencer_if #(
    parameter int DATA_WIDTH = 12
) ();

    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_valid;
    logic                         s_ready;
    logic                         s_sof;
    logic                         s_eol;

    modport master (
        output s_data, s_valid, s_sof, s_eol,
        input  s_ready
    );

    modport slave (
        input  s_data, s_valid, s_sof, s_eol,
        output s_ready
    );

endinterface

// File: rtl/lb_pos_counter.sv
// lb_pos_counter: col/row position of the next beat in a WIDTH x HEIGHT
// raster; wraps to (0,0) after the last pixel of a frame.
module lb_pos_counter
    import lb_seq_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      advance,
    output logic [cnt_w(WIDTH)-1:0]   col,
    output logic [cnt_w(HEIGHT)-1:0]  row,
    output logic                      line_last,
    output logic                      frame_last
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);

    assign line_last  = (col == XW'(WIDTH - 1));
    assign frame_last = line_last && (row == YW'(HEIGHT - 1));

    // Step one raster position per advance, wrapping at line and frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (line_last) begin
                col <= '0;
                row <= frame_last ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

endmodule

// File: rtl/lb_frame_sequencer.sv
// lb_frame_sequencer: frames the source stream into exactly WIDTH*HEIGHT
// line-buffer beats. Optional LB_SEQ_SOF_RESYNC_EN: stray SOF pads out frame.
module lb_frame_sequencer
    import lb_seq_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int DATA_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         continuous,
    lb_frame_sequencer_if.slave          src,
    output logic signed [DATA_WIDTH-1:0] lb_data,
    output logic                         lb_valid,
    output logic [cnt_w(WIDTH)-1:0]      lb_x,
    output logic [cnt_w(HEIGHT)-1:0]     lb_y,
    output logic                         busy,
    output logic                         frame_done,
    output logic [FRAME_CNT_W-1:0]       frame_count,
    output logic                         err_short_line,
    output logic                         err_long_line,
    output logic                         err_sof,
    input  logic                         err_clr
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);

    seq_state_t state, state_n;
    logic drop_end, drop_end_n;
    logic pad_frame, pad_frame_n;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic line_last, frame_last, at_origin;
    logic clr, adv, emit, beat, ready;
    logic signed [DATA_WIDTH-1:0] pix;
    logic set_short, set_long, set_sof;

    lb_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .advance    (adv),
        .col        (col),
        .row        (row),
        .line_last  (line_last),
        .frame_last (frame_last)
    );

    assign at_origin   = (col == '0) && (row == '0);
    assign src.s_ready = ready;
    assign busy        = (state != IDLE);

    // Next state, handshake, and which beat (if any) goes to the line buffer.
    always_comb begin
        state_n     = state;
        drop_end_n  = drop_end;
        pad_frame_n = pad_frame;
        ready       = 1'b0;
        beat        = 1'b0;
        emit        = 1'b0;
        adv         = 1'b0;
        clr         = 1'b0;
        pix         = src.s_data;
        set_short   = 1'b0;
        set_long    = 1'b0;
        set_sof     = 1'b0;
        unique case (state)
            IDLE: begin
                clr = 1'b1;
                if (start || continuous) state_n = WAIT_SOF;
            end
            WAIT_SOF: begin
                ready = 1'b1;
                beat  = src.s_valid && src.s_sof;
            end
            STREAM: begin
                ready = 1'b1;
                if (src.s_valid && src.s_sof && !at_origin) begin
                    set_sof = 1'b1;
`ifdef LB_SEQ_SOF_RESYNC_EN
                    ready       = 1'b0;
                    pad_frame_n = 1'b1;
                    state_n     = PAD;
`else
                    beat = 1'b1;
`endif
                end else begin
                    beat = src.s_valid;
                end
            end
            PAD: begin
                emit = 1'b1;
                adv  = 1'b1;
                pix  = '0;
                if (frame_last) state_n = END;
                else if (line_last && !pad_frame) state_n = STREAM;
            end
            DROP: begin
                ready = 1'b1;
                if (src.s_valid && src.s_eol)
                    state_n = drop_end ? END : STREAM;
            end
            END: begin
                pad_frame_n = 1'b0;
                state_n = (pad_frame || continuous) ? WAIT_SOF : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (beat) begin
            emit    = 1'b1;
            adv     = 1'b1;
            state_n = STREAM;
            if (line_last && src.s_eol) begin
                if (frame_last) state_n = END;
            end else if (line_last) begin
                set_long   = 1'b1;
                drop_end_n = frame_last;
                state_n    = DROP;
            end else if (src.s_eol) begin
                set_short = 1'b1;
                state_n   = PAD;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drop_end  <= 1'b0;
            pad_frame <= 1'b0;
        end else begin
            state     <= state_n;
            drop_end  <= drop_end_n;
            pad_frame <= pad_frame_n;
        end
    end

    // Registered line-buffer beat; data and position hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid <= 1'b0;
            lb_data  <= '0;
            lb_x     <= '0;
            lb_y     <= '0;
        end else begin
            lb_valid <= emit;
            if (emit) begin
                lb_data <= pix;
                lb_x    <= col;
                lb_y    <= row;
            end
        end
    end

    // Frame completion pulse, frame counter and sticky errors (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done     <= 1'b0;
            frame_count    <= '0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_sof        <= 1'b0;
        end else begin
            frame_done <= (state == END);
            if (state == END) frame_count <= frame_count + FRAME_CNT_W'(1);
            err_short_line <= set_short | (err_short_line & ~err_clr);
            err_long_line  <= set_long  | (err_long_line  & ~err_clr);
            err_sof        <= set_sof   | (err_sof        & ~err_clr);
        end
    end

endmodule

// File: tb/tb_lb_frame_sequencer.sv
// tb_lb_frame_sequencer: line-oriented reference model and scoreboard
// for lb_frame_sequencer at WIDTH=8, HEIGHT=6.
module tb_lb_frame_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic err_clr = 1'b0;
    logic signed [DW-1:0] lb_data;
    logic lb_valid;
    logic [2:0] lb_x, lb_y;
    logic busy, frame_done;
    logic [15:0] frame_count;
    logic err_short_line, err_long_line, err_sof;

    lb_frame_sequencer_if #(.DATA_WIDTH(DW)) src_if ();

    lb_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .continuous     (continuous),
        .src            (src_if),
        .lb_data        (lb_data),
        .lb_valid       (lb_valid),
        .lb_x           (lb_x),
        .lb_y           (lb_y),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .err_short_line (err_short_line),
        .err_long_line  (err_long_line),
        .err_sof        (err_sof),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            x;
        int            y;
        bit            last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit done_due = 1'b0;
    bit want_done;
    logic [DW-1:0] last_data = '0;
    int nbeats = 0;
    int frames_seen = 0;
    int exp_frames = 0;
    bit exp_short = 1'b0;
    bit exp_long = 1'b0;
    bit exp_sof = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    function automatic void push(input logic [DW-1:0] d, input int x, input int y, input bit last);
        exp_t t;
        t.d = d; t.x = x; t.y = y; t.last = last;
        q.push_back(t);
    endfunction

    // Compare process: every lb beat against the model queue, hold, frame_done.
    always @(negedge clk) begin
        if (chk_en) begin
            want_done = done_due;
            done_due = 1'b0;
            total++;
            if (frame_done !== want_done) begin
                bad++;
                $display("FAIL frame_done: got %b expected %b at %0t", frame_done, want_done, $time);
            end
            if (frame_done === 1'b1) frames_seen++;
            if (lb_valid === 1'b1) begin
                nbeats++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL lb_beat: unexpected beat (%0d,%0d) data %h", lb_x, lb_y, lb_data);
                end else begin
                    e = q.pop_front();
                    if (lb_data !== e.d || lb_x !== 3'(e.x) || lb_y !== 3'(e.y)) begin
                        bad++;
                        $display("FAIL lb_beat: got (%0d,%0d) %h expected (%0d,%0d) %h",
                                 lb_x, lb_y, lb_data, e.x, e.y, e.d);
                    end
                    if (e.last) done_due = 1'b1;
                end
                last_data = lb_data;
            end else begin
                total++;
                if (lb_valid !== 1'b0 || lb_data !== last_data) begin
                    bad++;
                    $display("FAIL lb_hold: got valid %b data %h expected 0 and %h",
                             lb_valid, lb_data, last_data);
                end
            end
        end
    end

    // One source beat, with random idle gaps, held until accepted.
    task automatic beat(input logic [DW-1:0] d, input bit sof, input bit eol);
        int w;
        bit rdy;
        while ($urandom_range(0, 3) == 0) begin
            src_if.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        src_if.s_valid = 1'b1;
        src_if.s_data  = d;
        src_if.s_sof   = sof;
        src_if.s_eol   = eol;
        w = 0;
        rdy = 1'b0;
        while (!rdy && w < 300) begin
            @(negedge clk);
            rdy = src_if.s_ready;
            @(posedge clk); #1;
            w++;
        end
        src_if.s_valid = 1'b0;
        src_if.s_sof   = 1'b0;
        src_if.s_eol   = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: s_ready 0 for %0d cycles, expected 1", w);
        end
    endtask

    // A source line of n pixels: the line buffer sees the first W, zero padded.
    task automatic send_line(input int r, input int n, input int sofc, input bit full);
        logic [DW-1:0] d [16];
        for (int i = 0; i < n; i++) d[i] = DW'($urandom);
        for (int i = 0; i < W; i++) begin
            if (i < n) push(d[i], i, r, full && r == H-1 && i == W-1);
            else if (full) push('0, i, r, r == H-1 && i == W-1);
        end
        if (full && n < W) exp_short = 1'b1;
        if (full && n > W) exp_long = 1'b1;
        for (int i = 0; i < n; i++) beat(d[i], i == sofc, full && i == n-1);
    endtask

    task automatic run_frame(input int lens [H], input int sr, input int sc, input int pre);
        for (int p = 0; p < pre; p++) beat(DW'($urandom), 1'b0, 1'($urandom));
        for (int r = 0; r < H; r++)
            send_line(r, lens[r], (r == 0) ? 0 : ((r == sr) ? sc : -1), 1'b1);
        if (sr >= 0) exp_sof = 1'b1;
        exp_frames++;
    endtask

    task automatic wait_done();
        int w = 0;
        while ((frames_seen != exp_frames || q.size() != 0) && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        chk("frames_seen", frames_seen, exp_frames);
        chk("queue_drained", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic frame_checks(input string tag, input int beats);
        chk({tag, "/beats"}, nbeats, beats);
        chk({tag, "/frame_count"}, frame_count, exp_frames);
        chk({tag, "/err_short_line"}, err_short_line, exp_short);
        chk({tag, "/err_long_line"}, err_long_line, exp_long);
        chk({tag, "/err_sof"}, err_sof, exp_sof);
        nbeats = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_short = 1'b0; exp_long = 1'b0; exp_sof = 1'b0;
        chk("clr/err_short_line", err_short_line, 0);
        chk("clr/err_long_line", err_long_line, 0);
        chk("clr/err_sof", err_sof, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/lb_valid"}, lb_valid, 0);
        chk({tag, "/lb_data"}, lb_data, 0);
        chk({tag, "/lb_x"}, lb_x, 0);
        chk({tag, "/lb_y"}, lb_y, 0);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/frame_done"}, frame_done, 0);
        chk({tag, "/frame_count"}, frame_count, 0);
        chk({tag, "/errs"}, {err_short_line, err_long_line, err_sof}, 0);
        chk({tag, "/s_ready"}, src_if.s_ready, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lens [H];
        src_if.s_valid = 1'b0;
        src_if.s_data  = '0;
        src_if.s_sof   = 1'b0;
        src_if.s_eol   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Clean frame
        for (int r = 0; r < H; r++) lens[r] = W;
        pulse_start();
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("clean", 48);
        chk("clean/count_lit", frame_count, 1);

        // Short line: row 2 ends at col 4
        lens[2] = 5;
        pulse_start();
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("short", 48);
        chk("short/err_lit", err_short_line, 1);
        clear_errs();

        // Long line: row 1 has 11 pixels
        lens[2] = W;
        lens[1] = 11;
        pulse_start();
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("long", 48);
        chk("long/err_lit", err_long_line, 1);
        clear_errs();

        // Preamble + continuous, two back-to-back frames
        lens[1] = W;
        continuous = 1'b1;
        run_frame(lens, -1, 0, 5);
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("cont", 96);
        chk("cont/busy_lit", busy, 1);
        continuous = 1'b0;

`ifdef LB_SEQ_SOF_RESYNC_EN
        // Stray SOF at (3,2): rest of frame zero padded, SOF starts next frame
        pulse_start();
        send_line(0, W, 0, 1'b1);
        send_line(1, W, -1, 1'b1);
        send_line(2, 3, -1, 1'b0);
        for (int p = 19; p < 48; p++) push('0, p % W, p / W, p == 47);
        exp_sof = 1'b1;
        exp_frames++;
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("resync", 96);
`else
        // Stray SOF at (3,2) treated as an ordinary pixel
        pulse_start();
        run_frame(lens, 2, 3, 0);
        wait_done();
        frame_checks("midsof", 48);
`endif
        chk("midsof/err_lit", err_sof, 1);
        clear_errs();

        // Randomized frames in continuous mode
        continuous = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int sr, sc, lim;
            for (int r = 0; r < H; r++)
                lens[r] = ($urandom_range(0, 2) == 0) ?
                          int'($urandom_range(W-3, (r == H-1) ? W : W+3)) : W;
            sr = -1;
            sc = 0;
`ifndef LB_SEQ_SOF_RESYNC_EN
            if ($urandom_range(0, 3) == 0) begin
                sr = $urandom_range(1, H-1);
                lim = (lens[sr] < W) ? lens[sr] : W;
                sc = $urandom_range(0, lim-1);
            end
`endif
            run_frame(lens, sr, sc, $urandom_range(0, 3));
            wait_done();
            frame_checks("rand", 48);
            clear_errs();
        end
        continuous = 1'b0;

        // Reset mid-frame at (5,3)
        pulse_start();
        send_line(0, W, 0, 1'b1);
        send_line(1, W, -1, 1'b1);
        send_line(2, W, -1, 1'b1);
        send_line(3, 5, -1, 1'b0);
        @(negedge clk); #1;
        chk("prereset/queue", q.size(), 0);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        q.delete();
        done_due = 1'b0;
        last_data = '0;
        exp_frames = 0;
        frames_seen = 0;
        nbeats = 0;
        exp_short = 1'b0; exp_long = 1'b0; exp_sof = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int r = 0; r < H; r++) lens[r] = W;
        pulse_start();
        run_frame(lens, -1, 0, 0);
        wait_done();
        frame_checks("postreset", 48);
        chk("postreset/count_lit", frame_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
